// File: rtl/axi_lite2mem_pkg.sv
// Shared types and helpers for the AXI-Lite to native memory bridge.
//   state_t       : bridge FSM states
//   grant_t       : last side granted by the read/write round-robin
//   RESP_*        : AXI response encodings
//   addr_in_range : word-aligned window decode
package axi_lite2mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MEM_RD = 3'd1,
    MEM_WR = 3'd2,
    RESP_R = 3'd3,
    RESP_B = 3'd4
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Offset-based compare so a window that ends at the top of the address space
  // and addresses below the base (which wrap to huge offsets) both decode right.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [31:0] offset;
    offset = (addr & 32'hFFFF_FFFC) - base;
    return (offset < size);
  endfunction

endpackage

// File: rtl/axi_lite2mem.sv
// AXI-Lite slave that turns one AXI-Lite read or write at a time into a
// native mem_valid/mem_ready request. Reads and writes are arbitrated
// round-robin, addresses outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) get SLVERR
// without touching memory, and a stalled memory is abandoned after
// TIMEOUT_CYCLES wait cycles (0 disables the timeout).
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*       : AXI-Lite write address, data and response channels
//   s_axi_ar*/r*          : AXI-Lite read address and data channels
//   mem_valid/mem_ready   : native request handshake
//   mem_addr/wdata/wstrb  : native request payload (wstrb 0 = read)
//   mem_rdata             : native read data, taken when mem_valid && mem_ready
//   mem_instr             : always 0 (data-side requester)
module axi_lite2mem
  import axi_lite2mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE      = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_t      state_r, state_n;
  grant_t      last_grant_r, last_grant_n;
  logic        aw_full_r, w_full_r;
  logic [31:0] awaddr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic [31:0] tmo_cnt_r, tmo_cnt_n;
  logic        mem_valid_r, mem_valid_n;
  logic [31:0] mem_addr_r, mem_addr_n, mem_wdata_r, mem_wdata_n;
  logic [3:0]  mem_wstrb_r, mem_wstrb_n;
  logic        rvalid_r, rvalid_n, bvalid_r, bvalid_n;
  logic [31:0] rdata_r, rdata_n;
  logic [1:0]  rresp_r, rresp_n, bresp_r, bresp_n;
  logic        wr_pend_s, rd_grant_s, wr_grant_s, wr_take_s, timeout_s;
  logic        idle_s, awready_s, wready_s;

  // A write competes only once both halves are held; a contest goes to the
  // side that did not win last time.
  assign idle_s     = (state_r == IDLE);
  assign wr_pend_s  = aw_full_r && w_full_r;
  assign rd_grant_s = s_axi_arvalid && (!wr_pend_s || (last_grant_r == WRITE));
  assign wr_grant_s = wr_pend_s && (!s_axi_arvalid || (last_grant_r == READ));
  assign awready_s  = !aw_full_r && idle_s;
  assign wready_s   = !w_full_r && idle_s;
  // The counter holds the number of completed wait cycles, so reaching
  // TIMEOUT_CYCLES-1 here means this is the last cycle mem_valid may be high.
  assign timeout_s  = (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1));

  assign s_axi_awready = awready_s;
  assign s_axi_wready  = wready_s;
  assign s_axi_arready = idle_s && rd_grant_s;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign mem_valid     = mem_valid_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_wstrb     = mem_wstrb_r;
  assign mem_instr     = 1'b0;

  // AW and W holding registers, filled independently, emptied when the write is granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      awaddr_r  <= 32'h0;
      wdata_r   <= 32'h0;
      wstrb_r   <= 4'h0;
    end else begin
      if (s_axi_awvalid && awready_s) begin
        aw_full_r <= 1'b1;
        awaddr_r  <= s_axi_awaddr;
      end else if (wr_take_s) begin
        aw_full_r <= 1'b0;
      end
      if (s_axi_wvalid && wready_s) begin
        w_full_r <= 1'b1;
        wdata_r  <= s_axi_wdata;
        wstrb_r  <= s_axi_wstrb;
      end else if (wr_take_s) begin
        w_full_r <= 1'b0;
      end
    end
  end

  // FSM state, arbitration history, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      last_grant_r <= WRITE;
      tmo_cnt_r    <= 32'h0;
      mem_valid_r  <= 1'b0;
      mem_addr_r   <= 32'h0;
      mem_wdata_r  <= 32'h0;
      mem_wstrb_r  <= 4'h0;
      rvalid_r     <= 1'b0;
      rdata_r      <= 32'h0;
      rresp_r      <= 2'b00;
      bvalid_r     <= 1'b0;
      bresp_r      <= 2'b00;
    end else begin
      state_r      <= state_n;
      last_grant_r <= last_grant_n;
      tmo_cnt_r    <= tmo_cnt_n;
      mem_valid_r  <= mem_valid_n;
      mem_addr_r   <= mem_addr_n;
      mem_wdata_r  <= mem_wdata_n;
      mem_wstrb_r  <= mem_wstrb_n;
      rvalid_r     <= rvalid_n;
      rdata_r      <= rdata_n;
      rresp_r      <= rresp_n;
      bvalid_r     <= bvalid_n;
      bresp_r      <= bresp_n;
    end
  end

  // Next-state and next-output logic; everything holds unless a branch changes it.
  always_comb begin
    state_n      = state_r;
    last_grant_n = last_grant_r;
    tmo_cnt_n    = tmo_cnt_r;
    mem_valid_n  = mem_valid_r;
    mem_addr_n   = mem_addr_r;
    mem_wdata_n  = mem_wdata_r;
    mem_wstrb_n  = mem_wstrb_r;
    rvalid_n     = rvalid_r;
    rdata_n      = rdata_r;
    rresp_n      = rresp_r;
    bvalid_n     = bvalid_r;
    bresp_n      = bresp_r;
    wr_take_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_grant_s) begin
          last_grant_n = READ;
          if (addr_in_range(s_axi_araddr, ADDR_BASE, ADDR_SIZE)) begin
            state_n     = MEM_RD;
            mem_valid_n = 1'b1;
            mem_addr_n  = {s_axi_araddr[31:2], 2'b00};
            mem_wdata_n = 32'h0;
            mem_wstrb_n = 4'h0;
            tmo_cnt_n   = 32'h0;
          end else begin
            state_n  = RESP_R;
            rvalid_n = 1'b1;
            rdata_n  = 32'h0;
            rresp_n  = RESP_SLVERR;
          end
        end else if (wr_grant_s) begin
          last_grant_n = WRITE;
          wr_take_s    = 1'b1;
          if (!addr_in_range(awaddr_r, ADDR_BASE, ADDR_SIZE)) begin
            state_n  = RESP_B;
            bvalid_n = 1'b1;
            bresp_n  = RESP_SLVERR;
          end else if (wstrb_r == 4'h0) begin
            // A zero-strobe write would look like a read on the native side.
            state_n  = RESP_B;
            bvalid_n = 1'b1;
            bresp_n  = RESP_OKAY;
          end else begin
            state_n     = MEM_WR;
            mem_valid_n = 1'b1;
            mem_addr_n  = {awaddr_r[31:2], 2'b00};
            mem_wdata_n = wdata_r;
            mem_wstrb_n = wstrb_r;
            tmo_cnt_n   = 32'h0;
          end
        end else begin
          state_n = IDLE;
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          mem_valid_n = 1'b0;
          state_n     = RESP_R;
          rvalid_n    = 1'b1;
          rdata_n     = mem_rdata;
          rresp_n     = RESP_OKAY;
        end else if (timeout_s) begin
          mem_valid_n = 1'b0;
          state_n     = RESP_R;
          rvalid_n    = 1'b1;
          rdata_n     = 32'h0;
          rresp_n     = RESP_SLVERR;
        end else begin
          tmo_cnt_n = tmo_cnt_r + 32'd1;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          mem_valid_n = 1'b0;
          state_n     = RESP_B;
          bvalid_n    = 1'b1;
          bresp_n     = RESP_OKAY;
        end else if (timeout_s) begin
          mem_valid_n = 1'b0;
          state_n     = RESP_B;
          bvalid_n    = 1'b1;
          bresp_n     = RESP_SLVERR;
        end else begin
          tmo_cnt_n = tmo_cnt_r + 32'd1;
        end
      end
      RESP_R: begin
        if (s_axi_rready) begin
          rvalid_n = 1'b0;
          state_n  = IDLE;
        end else begin
          rvalid_n = 1'b1;
        end
      end
      RESP_B: begin
        if (s_axi_bready) begin
          bvalid_n = 1'b0;
          state_n  = IDLE;
        end else begin
          bvalid_n = 1'b1;
        end
      end
      default: begin
        state_n     = IDLE;
        mem_valid_n = 1'b0;
        rvalid_n    = 1'b0;
        bvalid_n    = 1'b0;
      end
    endcase
  end

endmodule
